// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_ext_pipe : registered, handshaked immediate extender with prefix support
// Rev 1.0
// ---------------------------------------------------------------------------
module imm_ext_pipe #(
  parameter int unsigned XLEN       = 16,
  parameter bit          ZEXT_LOGIC = 1'b1,
  parameter bit          PREFIX_EN  = 1'b1,
  parameter logic [3:0]  PREFIX_OP  = 4'b1011
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [15:0]     out_instr,
  output logic            out_pfx_used,
  output logic            out_pfx_err
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_PFX_HELD = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [11:0]     pfx_q, pfx_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [15:0]     out_instr_q, out_instr_d;
  logic            out_pfx_used_q, out_pfx_used_d;
  logic            out_pfx_err_q, out_pfx_err_d;

  logic [3:0]      opcode;
  logic [7:0]      field;
  logic [7:0]      field_s8;
  logic            wide;
  logic            has_imm;
  logic            is_pfx;
  logic            zext_sel;
  logic            accept;
  logic [XLEN-1:0] field_sx;
  logic [XLEN-1:0] field_zx;
  logic [XLEN-1:0] pfx_sx;
  logic [XLEN-1:0] imm_pfx;

  assign opcode   = instr[3:0];
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_pfx   = PREFIX_EN && (opcode == PREFIX_OP);
  assign zext_sel = ZEXT_LOGIC && ((opcode == 4'b1110) || (opcode == 4'b1111));

  always_comb begin
    field   = 8'd0;
    wide    = 1'b0;
    has_imm = 1'b1;
    case (opcode)
      4'b0000: begin
        field = instr[15:8];
        wide  = 1'b1;
      end
      4'b0001, 4'b0100, 4'b0101,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: field = {4'b0000, instr[15:12]};
      4'b0010, 4'b0011, 4'b0110, 4'b0111: field = {4'b0000, instr[7:4]};
      default: has_imm = 1'b0;
    endcase
  end

  // The prefix supplies everything above the field, so the field itself is
  // always OR-ed in unextended.
  assign field_s8 = wide ? field : {{4{field[3]}}, field[3:0]};
  assign field_sx = XLEN'($signed(field_s8));
  assign field_zx = XLEN'(field);
  assign pfx_sx   = XLEN'($signed(pfx_q));
  assign imm_pfx  = (wide ? (pfx_sx << 8) : (pfx_sx << 4)) | field_zx;

  always_comb begin
    state_d        = state_q;
    pfx_d          = pfx_q;
    out_valid_d    = out_valid_q;
    out_imm_d      = out_imm_q;
    out_instr_d    = out_instr_q;
    out_pfx_used_d = out_pfx_used_q;
    out_pfx_err_d  = out_pfx_err_q;
    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
      pfx_d       = 12'd0;
    end else if (accept && is_pfx) begin
      pfx_d   = instr[15:4];
      state_d = S_PFX_HELD;
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = instr;
      state_d     = S_IDLE;
      if (!has_imm) begin
        out_imm_d      = '0;
        out_pfx_used_d = 1'b0;
        out_pfx_err_d  = (state_q == S_PFX_HELD);
      end else if (state_q == S_PFX_HELD) begin
        out_imm_d      = imm_pfx;
        out_pfx_used_d = 1'b1;
        out_pfx_err_d  = 1'b0;
      end else begin
        out_imm_d      = zext_sel ? field_zx : field_sx;
        out_pfx_used_d = 1'b0;
        out_pfx_err_d  = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pfx_q          <= 12'd0;
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_instr_q    <= 16'd0;
      out_pfx_used_q <= 1'b0;
      out_pfx_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pfx_q          <= pfx_d;
      out_valid_q    <= out_valid_d;
      out_imm_q      <= out_imm_d;
      out_instr_q    <= out_instr_d;
      out_pfx_used_q <= out_pfx_used_d;
      out_pfx_err_q  <= out_pfx_err_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_imm      = out_imm_q;
  assign out_instr    = out_instr_q;
  assign out_pfx_used = out_pfx_used_q;
  assign out_pfx_err  = out_pfx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imm_ext_pipe : self-checking bench for imm_ext_pipe
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] instr;
  logic        flush;
  logic        out_ready;

  logic        in_ready0, out_valid0, used0, err0;
  logic [15:0] imm0, oinstr0;
  logic        in_ready1, out_valid1, used1, err1;
  logic [15:0] imm1, oinstr1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(16), .ZEXT_LOGIC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .instr(instr), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .out_imm(imm0), .out_instr(oinstr0), .out_pfx_used(used0), .out_pfx_err(err0)
  );

  imm_ext_pipe #(.XLEN(16), .ZEXT_LOGIC(1'b0)) dut_sx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .instr(instr), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .out_imm(imm1), .out_instr(oinstr1), .out_pfx_used(used1), .out_pfx_err(err1)
  );

  typedef struct {
    logic [15:0] ins;
    logic [15:0] imm_z;
    logic [15:0] imm_s;
  } vec_t;

  vec_t tbl[15];

  // reference model state
  bit          m_ov, m_pv, m_used, m_err, m_rdy, m_acc;
  logic [11:0] m_pfx;
  logic [15:0] m_imm, m_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void field_of(input logic [15:0] ins, output bit has, output int f, output int w);
    has = 1'b1;
    w   = 4;
    f   = 0;
    case (ins[3:0])
      4'h0: begin f = int'(ins[15:8]); w = 8; end
      4'h1, 4'h4, 4'h5, 4'hC, 4'hD, 4'hE, 4'hF: f = int'(ins[15:12]);
      4'h2, 4'h3, 4'h6, 4'h7: f = int'(ins[7:4]);
      default: has = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] ref_imm(input logic [15:0] ins, input bit pv,
                                          input logic [11:0] p, input bit zl);
    bit has;
    int f, w, sp, v;
    field_of(ins, has, f, w);
    if (!has) return 16'h0000;
    if (pv) begin
      sp = int'(p);
      if (sp >= 2048) sp -= 4096;
      v = sp * (1 << w) + f;
    end else if (zl && (ins[3:0] >= 4'hE)) begin
      v = f;
    end else begin
      v = f;
      if (f >= (1 << (w - 1))) v -= (1 << w);
    end
    return v[15:0];
  endfunction

  task automatic send(input logic [15:0] ins);
    in_valid = 1'b1;
    instr    = ins;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    bit has;
    int f, w;
    logic [31:0] r;

    tbl[0]  = '{16'hF00C, 16'hFFFF, 16'hFFFF};
    tbl[1]  = '{16'hF00E, 16'h000F, 16'hFFFF};
    tbl[2]  = '{16'h8000, 16'hFF80, 16'hFF80};
    tbl[3]  = '{16'h0077, 16'h0007, 16'h0007};
    tbl[4]  = '{16'hFFF8, 16'h0000, 16'h0000};
    tbl[5]  = '{16'h7001, 16'h0007, 16'h0007};
    tbl[6]  = '{16'h0082, 16'hFFF8, 16'hFFF8};
    tbl[7]  = '{16'h9005, 16'hFFF9, 16'hFFF9};
    tbl[8]  = '{16'h800F, 16'h0008, 16'hFFF8};
    tbl[9]  = '{16'h800D, 16'hFFF8, 16'hFFF8};
    tbl[10] = '{16'h1239, 16'h0000, 16'h0000};
    tbl[11] = '{16'h1004, 16'h0001, 16'h0001};
    tbl[12] = '{16'h05F3, 16'hFFFF, 16'hFFFF};
    tbl[13] = '{16'h0016, 16'h0001, 16'h0001};
    tbl[14] = '{16'hABCA, 16'h0000, 16'h0000};

    rst_n = 1'b0; in_valid = 1'b0; instr = 16'h0000; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_imm", imm0, 0);
    chk("rst_out_instr", oinstr0, 0);
    chk("rst_flags", {used0, err0}, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready0, 1);

    // back-to-back table, full throughput
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      instr    = tbl[i].ins;
      tick();
      chk("tbl_valid", out_valid0, 1);
      chk("tbl_imm_zext", imm0, tbl[i].imm_z);
      chk("tbl_imm_sext", imm1, tbl[i].imm_s);
      chk("tbl_instr", oinstr0, tbl[i].ins);
      chk("tbl_flags", {used0, err0}, 0);
    end
    in_valid = 1'b0;
    tick();
    chk("tbl_drain", out_valid0, 0);

    // prefix + addi
    send(16'h123B);
    chk("pfx_no_output", out_valid0, 0);
    send(16'h500C);
    chk("pfx_addi_valid", out_valid0, 1);
    chk("pfx_addi_imm", imm0, 16'h1235);
    chk("pfx_addi_used", {used0, err0}, 2'b10);
    tick();
    chk("pfx_single_output", out_valid0, 0);

    // prefix + jal
    send(16'h00AB);
    send(16'h3400);
    chk("pfx_jal_imm", imm0, 16'h0A34);
    chk("pfx_jal_used", used0, 1);
    tick();

    // backpressure
    out_ready = 1'b0;
    send(16'hF00C);
    chk("stall_first", {out_valid0, imm0}, {1'b1, 16'hFFFF});
    in_valid = 1'b1;
    instr    = 16'h8000;
    #1;
    chk("stall_in_ready", in_ready0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", {out_valid0, imm0, oinstr0}, {1'b1, 16'hFFFF, 16'hF00C});
      chk("stall_in_ready", in_ready0, 0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("stall_release", {out_valid0, imm0, oinstr0}, {1'b1, 16'hFF80, 16'h8000});
    tick();
    chk("stall_drain", out_valid0, 0);

    // flush drops the prefix
    send(16'h123B);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    send(16'h500C);
    chk("flush_pfx_imm", imm0, 16'h0005);
    chk("flush_pfx_used", used0, 0);
    tick();

    // flush drops held output and wins over in_valid/out_ready
    out_ready = 1'b0;
    send(16'hF00C);
    chk("flush_held_valid", out_valid0, 1);
    flush = 1'b1; in_valid = 1'b1; instr = 16'h500C; out_ready = 1'b1;
    #1;
    chk("flush_in_ready", in_ready0, 0);
    tick();
    chk("flush_clears", out_valid0, 0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_no_accept", out_valid0, 0);

    // prefix followed by non-immediate instruction
    send(16'h123B);
    send(16'hFFF8);
    chk("pfx_err_imm", imm0, 0);
    chk("pfx_err_flags", {used0, err0}, 2'b01);
    tick();

    // reset drops the prefix
    send(16'h123B);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_valid", out_valid0, 0);
    rst_n = 1'b1;
    send(16'h500C);
    chk("rst_mid_imm", {imm0, used0}, {16'h0005, 1'b0});
    tick();
    chk("rst_mid_drain", out_valid0, 0);

    // randomized run against the reference model
    m_ov = 0; m_pv = 0; m_pfx = 0; m_imm = 0; m_instr = 0; m_used = 0; m_err = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      r         = $urandom;
      instr     = r[15:0];
      if ($urandom_range(0, 4) == 0) instr[3:0] = 4'hB;
      #1;
      m_rdy = !flush && (!m_ov || out_ready);
      m_acc = in_valid && m_rdy;
      chk("rnd_in_ready", in_ready0, m_rdy);
      if (flush) begin
        m_ov = 0;
        m_pv = 0;
      end else if (m_acc && instr[3:0] == 4'hB) begin
        m_pv  = 1;
        m_pfx = instr[15:4];
        if (out_ready) m_ov = 0;
      end else if (m_acc) begin
        field_of(instr, has, f, w);
        m_ov    = 1;
        m_imm   = ref_imm(instr, m_pv, m_pfx, 1'b1);
        m_instr = instr;
        m_used  = m_pv && has;
        m_err   = m_pv && !has;
        m_pv    = 0;
      end else if (out_ready) begin
        m_ov = 0;
      end
      tick();
      chk("rnd_out_valid", out_valid0, m_ov);
      if (m_ov) begin
        chk("rnd_out_imm", imm0, m_imm);
        chk("rnd_out_instr", oinstr0, m_instr);
        chk("rnd_flags", {used0, err0}, {m_used, m_err});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
